// File: rtl/io_port_master.sv
// io_port_master: PicoBlaze-style IO port bus initiator for raw IN/OUT and blocking UART PUT/GET.
module io_port_master #(
    parameter logic [7:0]  PORT_DATA      = 8'h01,
    parameter logic [7:0]  PORT_RXP       = 8'h02,
    parameter logic [7:0]  PORT_TXF       = 8'h03,
    parameter int unsigned POST_WRITE_GAP = 2,
    parameter int unsigned POLL_LIMIT     = 0
) (
    input  logic       clk6,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [1:0] req_op,
    input  logic [7:0] req_port,
    input  logic [7:0] req_wdata,
    output logic       done,
    output logic [7:0] rdata,
    output logic       err,
    output logic [7:0] io_port_id,
    output logic [7:0] io_write_data,
    output logic       io_write_strobe,
    output logic       io_read_strobe,
    input  logic [7:0] io_read_data
);
    typedef enum logic [2:0] {IDLE, WR_STB, RD_STB, RD_WAIT, POLL_STB, POLL_WAIT, GAP, DONE} state_t;
    localparam logic [1:0]  OP_OUT   = 2'b00;
    localparam logic [1:0]  OP_IN    = 2'b01;
    localparam logic [1:0]  OP_PUT   = 2'b10;
    localparam logic [1:0]  OP_GET   = 2'b11;
    localparam logic [3:0]  GAP_LAST = 4'((POST_WRITE_GAP == 0) ? 0 : POST_WRITE_GAP - 1);
    localparam logic [15:0] LIMIT    = 16'(POLL_LIMIT);
    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [7:0]  port_q, port_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [7:0]  port_id_q, port_id_d, wr_data_q, wr_data_d;
    logic [15:0] cnt_q, cnt_d;
    logic [3:0]  gap_q, gap_d;
    logic        err_q, err_d, wstb_q, rstb_q, abort, poll_met;
    assign req_ready       = !reset && (state_q == IDLE || state_q == DONE);
    assign done            = state_q == DONE;
    assign rdata           = rdata_q;
    assign err             = err_q;
    assign io_port_id      = port_id_q;
    assign io_write_data   = wr_data_q;
    assign io_write_strobe = wstb_q;
    assign io_read_strobe  = rstb_q;
    // PUT waits for TX-full to clear; GET waits for RX-present to set
    assign poll_met = (op_q == OP_PUT) ? ~io_read_data[0] : io_read_data[0];
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        port_d    = port_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        rdata_d   = rdata_q;
        err_d     = err_q;
        port_id_d = port_id_q;
        wr_data_d = wr_data_q;
        abort     = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (req_valid && req_ready) begin
                    op_d    = req_op;
                    port_d  = req_port;
                    wdata_d = req_wdata;
                    cnt_d   = '0;
                    state_d = (req_op == OP_OUT) ? WR_STB : (req_op == OP_IN) ? RD_STB : POLL_STB;
                end
            end
            WR_STB: begin
                state_d = (POST_WRITE_GAP == 0) ? DONE : GAP;
                gap_d   = GAP_LAST;
            end
            RD_STB:   state_d = RD_WAIT;
            RD_WAIT: begin
                rdata_d = io_read_data;
                state_d = DONE;
            end
            POLL_STB: state_d = POLL_WAIT;
            POLL_WAIT: begin
                if (poll_met) begin
                    // GET takes a single turnaround cycle in GAP before the data read
                    state_d = (op_q == OP_PUT) ? WR_STB : GAP;
                    gap_d   = '0;
                end else begin
                    cnt_d   = cnt_q + 16'd1;
                    abort   = (POLL_LIMIT != 0) && (cnt_d == LIMIT);
                    state_d = abort ? DONE : POLL_STB;
                end
            end
            GAP: begin
                gap_d = gap_q - 4'd1;
                if (gap_q == 4'd0) state_d = (op_q == OP_GET) ? RD_STB : DONE;
            end
            default:  state_d = IDLE;
        endcase
        if (state_d == DONE) err_d = abort;
        if (state_d == WR_STB) begin
            port_id_d = (op_d == OP_OUT) ? port_d : PORT_DATA;
            wr_data_d = wdata_d;
        end
        if (state_d == RD_STB) port_id_d = (op_d == OP_IN) ? port_d : PORT_DATA;
        if (state_d == POLL_STB) port_id_d = (op_d == OP_PUT) ? PORT_TXF : PORT_RXP;
    end
    always_ff @(posedge clk6) begin
        if (reset) begin
            state_q   <= IDLE;
            op_q      <= '0;
            port_q    <= '0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            port_id_q <= '0;
            wr_data_q <= '0;
            wstb_q    <= 1'b0;
            rstb_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            port_q    <= port_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            gap_q     <= gap_d;
            rdata_q   <= rdata_d;
            err_q     <= err_d;
            port_id_q <= port_id_d;
            wr_data_q <= wr_data_d;
            wstb_q    <= state_d == WR_STB;
            rstb_q    <= state_d == RD_STB || state_d == POLL_STB;
        end
    end
endmodule

// File: tb/tb_io_port_master.sv
// tb_io_port_master: directed bench for io_port_master with a scripted IO responder.
module tb_io_port_master;
    logic       clk6 = 1'b0, reset = 1'b1, req_valid = 1'b0;
    logic [1:0] req_op = '0;
    logic [7:0] req_port = '0, req_wdata = '0, io_read_data = '0;
    logic       req_ready, done, err, io_write_strobe, io_read_strobe;
    logic [7:0] rdata, io_port_id, io_write_data;
    int pass = 0, total = 0, cyc = 0, t0 = 0, overlap = 0;
    logic [7:0] txf_q[$], rxp_q[$];
    logic [7:0] txf_stuck = 8'h00, rxp_stuck = 8'h00, data_val = 8'h00;
    int rd_cyc[$], wr_cyc[$], done_cyc[$];
    logic [7:0] rd_port[$], wr_port[$], wr_data[$];
    io_port_master #(.POST_WRITE_GAP(2), .POLL_LIMIT(4)) dut (
        .clk6(clk6), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_port(req_port), .req_wdata(req_wdata),
        .done(done), .rdata(rdata), .err(err), .io_port_id(io_port_id),
        .io_write_data(io_write_data), .io_write_strobe(io_write_strobe),
        .io_read_strobe(io_read_strobe), .io_read_data(io_read_data)
    );
    always #5 clk6 = ~clk6;
    always @(posedge clk6) cyc <= cyc + 1;
    // responder registers read data on the strobe edge; status ports replay a script then a stuck value
    always @(posedge clk6) begin
        if (io_read_strobe) begin
            case (io_port_id)
                8'h01:   io_read_data <= data_val;
                8'h02:   io_read_data <= (rxp_q.size() > 0) ? rxp_q.pop_front() : rxp_stuck;
                8'h03:   io_read_data <= (txf_q.size() > 0) ? txf_q.pop_front() : txf_stuck;
                default: io_read_data <= 8'hC3;
            endcase
        end
    end
    always @(negedge clk6) begin
        if (io_read_strobe) begin rd_cyc.push_back(cyc); rd_port.push_back(io_port_id); end
        if (io_write_strobe) begin wr_cyc.push_back(cyc); wr_port.push_back(io_port_id); wr_data.push_back(io_write_data); end
        if (io_read_strobe && io_write_strobe) overlap++;
        if (done) done_cyc.push_back(cyc);
    end
    task automatic step();
        @(negedge clk6);
        #1;
    endtask
    // cycle T+k of a request shows up in the logs as cyc == t0 + k - 1
    task automatic start(input logic [1:0] op, input logic [7:0] port, input logic [7:0] wd);
        rd_cyc.delete(); rd_port.delete(); wr_cyc.delete(); wr_port.delete(); wr_data.delete(); done_cyc.delete();
        req_valid = 1'b1; req_op = op; req_port = port; req_wdata = wd;
        t0 = cyc + 1;
        step();
        req_valid = 1'b0;
    endtask
    task automatic wait_done();
        for (int i = 0; i < 40 && done_cyc.size() == 0; i++) step();
        repeat (4) step();
    endtask
    task automatic test_reset();
        repeat (3) step();
        total++; if (io_write_strobe !== 1'b0) $display("FAIL reset_wstb got %b want 0", io_write_strobe); else pass++;
        total++; if (io_read_strobe !== 1'b0) $display("FAIL reset_rstb got %b want 0", io_read_strobe); else pass++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else pass++;
        total++; if (err !== 1'b0) $display("FAIL reset_err got %b want 0", err); else pass++;
        total++; if (rdata !== 8'h00) $display("FAIL reset_rdata got %h want 00", rdata); else pass++;
        total++; if (io_port_id !== 8'h00) $display("FAIL reset_port got %h want 00", io_port_id); else pass++;
        total++; if (io_write_data !== 8'h00) $display("FAIL reset_wdata got %h want 00", io_write_data); else pass++;
        total++; if (req_ready !== 1'b0) $display("FAIL reset_ready_in_reset got %b want 0", req_ready); else pass++;
        reset = 1'b0;
        step();
        total++; if (req_ready !== 1'b1) $display("FAIL reset_ready_after got %b want 1", req_ready); else pass++;
    endtask
    task automatic test_out();
        start(2'b00, 8'h05, 8'hA5);
        total++; if (req_ready !== 1'b0) $display("FAIL out_busy_ready got %b want 0", req_ready); else pass++;
        wait_done();
        total++; if (wr_cyc.size() != 1) $display("FAIL out_wr_count got %0d want 1", wr_cyc.size()); else pass++;
        total++; if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) != t0) $display("FAIL out_wr_cycle got %0d want %0d", wr_cyc.size() > 0 ? wr_cyc[0] : -1, t0); else pass++;
        total++; if ((wr_port.size() > 0 ? wr_port[0] : 8'hxx) !== 8'h05) $display("FAIL out_wr_port got %h want 05", wr_port.size() > 0 ? wr_port[0] : 8'hxx); else pass++;
        total++; if ((wr_data.size() > 0 ? wr_data[0] : 8'hxx) !== 8'hA5) $display("FAIL out_wr_data got %h want a5", wr_data.size() > 0 ? wr_data[0] : 8'hxx); else pass++;
        total++; if (rd_cyc.size() != 0) $display("FAIL out_rd_count got %0d want 0", rd_cyc.size()); else pass++;
        total++; if (done_cyc.size() != 1) $display("FAIL out_done_count got %0d want 1", done_cyc.size()); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 3) $display("FAIL out_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 3); else pass++;
        total++; if (err !== 1'b0) $display("FAIL out_err got %b want 0", err); else pass++;
        total++; if (io_port_id !== 8'h05 || io_write_data !== 8'hA5) $display("FAIL out_hold got %h/%h want 05/a5", io_port_id, io_write_data); else pass++;
    endtask
    task automatic test_in();
        rxp_q = '{8'h01};
        start(2'b01, 8'h02, 8'h00);
        wait_done();
        total++; if (rd_cyc.size() != 1) $display("FAIL in_rd_count got %0d want 1", rd_cyc.size()); else pass++;
        total++; if ((rd_cyc.size() > 0 ? rd_cyc[0] : -1) != t0) $display("FAIL in_rd_cycle got %0d want %0d", rd_cyc.size() > 0 ? rd_cyc[0] : -1, t0); else pass++;
        total++; if ((rd_port.size() > 0 ? rd_port[0] : 8'hxx) !== 8'h02) $display("FAIL in_rd_port got %h want 02", rd_port.size() > 0 ? rd_port[0] : 8'hxx); else pass++;
        total++; if (wr_cyc.size() != 0) $display("FAIL in_wr_count got %0d want 0", wr_cyc.size()); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 2) $display("FAIL in_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 2); else pass++;
        total++; if (rdata !== 8'h01) $display("FAIL in_rdata got %h want 01", rdata); else pass++;
        total++; if (err !== 1'b0) $display("FAIL in_err got %b want 0", err); else pass++;
    endtask
    task automatic test_put();
        txf_q = '{8'h01, 8'h01, 8'h00};
        start(2'b10, 8'hEE, 8'h41);
        wait_done();
        total++; if (rd_cyc.size() != 3) $display("FAIL put_poll_count got %0d want 3", rd_cyc.size()); else pass++;
        total++; if ((rd_cyc.size() > 1 ? rd_cyc[1] : -1) != t0 + 2) $display("FAIL put_poll2_cycle got %0d want %0d", rd_cyc.size() > 1 ? rd_cyc[1] : -1, t0 + 2); else pass++;
        total++; if ((rd_cyc.size() > 2 ? rd_cyc[2] : -1) != t0 + 4) $display("FAIL put_poll3_cycle got %0d want %0d", rd_cyc.size() > 2 ? rd_cyc[2] : -1, t0 + 4); else pass++;
        total++; if ((rd_port.size() > 2 ? rd_port[2] : 8'hxx) !== 8'h03) $display("FAIL put_poll_port got %h want 03", rd_port.size() > 2 ? rd_port[2] : 8'hxx); else pass++;
        total++; if (wr_cyc.size() != 1) $display("FAIL put_wr_count got %0d want 1", wr_cyc.size()); else pass++;
        total++; if ((wr_cyc.size() > 0 ? wr_cyc[0] : -1) != t0 + 6) $display("FAIL put_wr_cycle got %0d want %0d", wr_cyc.size() > 0 ? wr_cyc[0] : -1, t0 + 6); else pass++;
        total++; if ((wr_port.size() > 0 ? wr_port[0] : 8'hxx) !== 8'h01) $display("FAIL put_wr_port got %h want 01", wr_port.size() > 0 ? wr_port[0] : 8'hxx); else pass++;
        total++; if ((wr_data.size() > 0 ? wr_data[0] : 8'hxx) !== 8'h41) $display("FAIL put_wr_data got %h want 41", wr_data.size() > 0 ? wr_data[0] : 8'hxx); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 9) $display("FAIL put_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 9); else pass++;
    endtask
    task automatic test_get();
        rxp_q = '{8'h00, 8'h00, 8'h01};
        data_val = 8'h5A;
        start(2'b11, 8'hEE, 8'h00);
        wait_done();
        total++; if (rd_cyc.size() != 4) $display("FAIL get_rd_count got %0d want 4", rd_cyc.size()); else pass++;
        total++; if ((rd_port.size() > 2 ? rd_port[2] : 8'hxx) !== 8'h02) $display("FAIL get_poll_port got %h want 02", rd_port.size() > 2 ? rd_port[2] : 8'hxx); else pass++;
        total++; if ((rd_port.size() > 3 ? rd_port[3] : 8'hxx) !== 8'h01) $display("FAIL get_data_port got %h want 01", rd_port.size() > 3 ? rd_port[3] : 8'hxx); else pass++;
        total++; if ((rd_cyc.size() > 3 ? rd_cyc[3] : -1) != t0 + 7) $display("FAIL get_data_cycle got %0d want %0d", rd_cyc.size() > 3 ? rd_cyc[3] : -1, t0 + 7); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 9) $display("FAIL get_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 9); else pass++;
        total++; if (rdata !== 8'h5A) $display("FAIL get_rdata got %h want 5a", rdata); else pass++;
        total++; if (wr_cyc.size() != 0) $display("FAIL get_wr_count got %0d want 0", wr_cyc.size()); else pass++;
        rxp_q = '{8'hFF};
        data_val = 8'h3C;
        start(2'b11, 8'hEE, 8'h00);
        wait_done();
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 5) $display("FAIL get_min_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 5); else pass++;
        total++; if (rdata !== 8'h3C) $display("FAIL get_min_rdata got %h want 3c", rdata); else pass++;
    endtask
    task automatic test_poll_limit();
        rxp_q.delete();
        rxp_stuck = 8'hFE;
        data_val = 8'h99;
        start(2'b11, 8'hEE, 8'h00);
        wait_done();
        total++; if (rd_cyc.size() != 4) $display("FAIL lim_poll_count got %0d want 4", rd_cyc.size()); else pass++;
        total++; if ((rd_port.size() > 3 ? rd_port[3] : 8'hxx) !== 8'h02) $display("FAIL lim_last_port got %h want 02", rd_port.size() > 3 ? rd_port[3] : 8'hxx); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 8) $display("FAIL lim_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 8); else pass++;
        total++; if (err !== 1'b1) $display("FAIL lim_err got %b want 1", err); else pass++;
        total++; if (rdata !== 8'h3C) $display("FAIL lim_rdata got %h want 3c", rdata); else pass++;
    endtask
    task automatic test_busy();
        rxp_q = '{8'h77};
        start(2'b01, 8'h02, 8'h00);
        req_valid = 1'b1; req_op = 2'b00; req_port = 8'h09; req_wdata = 8'h11;
        step();
        req_valid = 1'b0;
        wait_done();
        total++; if (wr_cyc.size() != 0) $display("FAIL busy_wr_count got %0d want 0", wr_cyc.size()); else pass++;
        total++; if (done_cyc.size() != 1) $display("FAIL busy_done_count got %0d want 1", done_cyc.size()); else pass++;
        total++; if (rdata !== 8'h77) $display("FAIL busy_rdata got %h want 77", rdata); else pass++;
        total++; if (err !== 1'b0) $display("FAIL busy_err_cleared got %b want 0", err); else pass++;
    endtask
    task automatic test_reset_mid();
        txf_stuck = 8'h01;
        start(2'b10, 8'hEE, 8'h55);
        step();
        reset = 1'b1;
        step();
        total++; if (io_read_strobe !== 1'b0 || io_write_strobe !== 1'b0) $display("FAIL mid_strobes got %b%b want 00", io_read_strobe, io_write_strobe); else pass++;
        step();
        reset = 1'b0;
        step();
        total++; if (req_ready !== 1'b1) $display("FAIL mid_ready got %b want 1", req_ready); else pass++;
        total++; if (done_cyc.size() != 0) $display("FAIL mid_no_done got %0d want 0", done_cyc.size()); else pass++;
        txf_stuck = 8'h00;
        start(2'b00, 8'h07, 8'h3E);
        wait_done();
        total++; if (wr_cyc.size() != 1 || (wr_data.size() > 0 ? wr_data[0] : 8'hxx) !== 8'h3E) $display("FAIL mid_out_write got %0d writes want 1 of 3e", wr_cyc.size()); else pass++;
        total++; if ((done_cyc.size() > 0 ? done_cyc[0] : -1) != t0 + 3) $display("FAIL mid_out_done_cycle got %0d want %0d", done_cyc.size() > 0 ? done_cyc[0] : -1, t0 + 3); else pass++;
        total++; if (rd_cyc.size() != 0) $display("FAIL mid_out_rd_count got %0d want 0", rd_cyc.size()); else pass++;
    endtask
    initial begin
        test_reset();
        test_out();
        test_in();
        test_put();
        test_get();
        test_poll_limit();
        test_busy();
        test_reset_mid();
        total++; if (overlap != 0) $display("FAIL strobe_overlap got %0d want 0", overlap); else pass++;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
